// File: rtl/ads_spi_capture.sv
// ads_spi_capture: periodic CONVST / BUSY handshake / 64-bit SPI read-out of a
// 4-channel simultaneous-sampling ADC. Each frame is presented to the decimator
// as four held 16-bit words with a shared, multi-cycle enable pulse.
module ads_spi_capture #(
    parameter int unsigned SCLK_DIV      = 4,
    parameter int unsigned SAMPLE_PERIOD = 2000,
    parameter int unsigned CONVST_WIDTH  = 8,
    parameter int unsigned BUSY_TIMEOUT  = 1024,
    parameter int unsigned EN_HOLD       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        adc_busy,
    input  logic        adc_sdo,
    output logic        adc_convst,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [15:0] Data0_out,
    output logic [15:0] Data1_out,
    output logic [15:0] Data2_out,
    output logic [15:0] Data3_out,
    output logic        Data0_out_en,
    output logic        Data1_out_en,
    output logic        Data2_out_en,
    output logic        Data3_out_en,
    output logic        overrun,
    output logic        busy_timeout
);

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 16;
    localparam int unsigned FRAME_W = NUM_CH * CH_W;
    // One leading SCLK-high phase, then a low and a high phase per bit.
    localparam int unsigned PHASES  = 2 * FRAME_W + 1;
    localparam int unsigned PH_W    = $clog2(PHASES);
    localparam int unsigned PER_W   = $clog2(SAMPLE_PERIOD);
    localparam int unsigned MAX_AB  = (CONVST_WIDTH > BUSY_TIMEOUT) ? CONVST_WIDTH : BUSY_TIMEOUT;
    localparam int unsigned MAX_CD  = (EN_HOLD > SCLK_DIV) ? EN_HOLD : SCLK_DIV;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_READ,
        ST_LATCH,
        ST_HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [FRAME_W-1:0]   data_q, data_d;
    logic                 en_q, en_d;
    logic                 convst_q, convst_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [PER_W-1:0]     per_cnt_q, per_cnt_d;
    logic                 busy_meta_q, busy_meta_d;
    logic                 busy_sync_q, busy_sync_d;
    logic                 sdo_meta_q, sdo_meta_d;
    logic                 sdo_sync_q, sdo_sync_d;
    logic                 tick;

    // Input synchronisers and the free-running sample-period counter.
    always_comb begin
        busy_meta_d = adc_busy;
        busy_sync_d = busy_meta_q;
        sdo_meta_d  = adc_sdo;
        sdo_sync_d  = sdo_meta_q;
        per_cnt_d   = '0;
        if (run) begin
            if (per_cnt_q == PER_W'(SAMPLE_PERIOD - 1)) begin
                per_cnt_d = '0;
            end else begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end
        end
    end

    assign tick = run && (per_cnt_q == '0);

    // Frame sequencer: next state and next values of every registered output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        data_d    = data_q;
        en_d      = 1'b0;
        convst_d  = 1'b0;
        cs_n_d    = 1'b1;
        sclk_d    = 1'b1;
        timeout_d = timeout_q;
        // A tick that finds a frame in flight is dropped and remembered.
        overrun_d = overrun_q | (tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d  = ST_CONVST;
                    cnt_d    = '0;
                    convst_d = 1'b1;
                end
            end

            ST_CONVST: begin
                if (cnt_q == CNT_W'(CONVST_WIDTH - 1)) begin
                    state_d = ST_WAIT_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    convst_d = 1'b1;
                end
            end

            ST_WAIT_HI: begin
                if (busy_sync_q) begin
                    state_d = ST_WAIT_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT_LO: begin
                if (!busy_sync_q) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    phase_d = '0;
                    cs_n_d  = 1'b0;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_READ: begin
                cs_n_d = 1'b0;
                sclk_d = sclk_q;
                if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (phase_q == PH_W'(PHASES - 1)) begin
                        // Trailing high phase done: release chip select.
                        state_d = ST_LATCH;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                        sclk_d  = ~sclk_q;
                        // Sample on the edge that takes SCLK high.
                        if (!sclk_q) begin
                            shift_d = {shift_q[FRAME_W-2:0], sdo_sync_q};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_LATCH: begin
                data_d  = shift_q;
                en_d    = 1'b1;
                state_d = ST_HOLD;
                cnt_d   = '0;
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(EN_HOLD - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    en_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            en_q        <= 1'b0;
            convst_q    <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            per_cnt_q   <= '0;
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
            sdo_meta_q  <= 1'b0;
            sdo_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            en_q        <= en_d;
            convst_q    <= convst_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            per_cnt_q   <= per_cnt_d;
            busy_meta_q <= busy_meta_d;
            busy_sync_q <= busy_sync_d;
            sdo_meta_q  <= sdo_meta_d;
            sdo_sync_q  <= sdo_sync_d;
        end
    end

    assign adc_convst   = convst_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign Data0_out    = data_q[63:48];
    assign Data1_out    = data_q[47:32];
    assign Data2_out    = data_q[31:16];
    assign Data3_out    = data_q[15:0];
    assign Data0_out_en = en_q;
    assign Data1_out_en = en_q;
    assign Data2_out_en = en_q;
    assign Data3_out_en = en_q;
    assign overrun      = overrun_q;
    assign busy_timeout = timeout_q;

endmodule

// File: tb/tb_ads_spi_capture.sv
// Bench for ads_spi_capture: behavioural ADC model, frame scoreboard and
// SPI/CONVST/enable timing monitors.
`timescale 1ns/1ps
module tb_ads_spi_capture;

    localparam int unsigned SCLK_DIV      = 4;
    localparam int unsigned SAMPLE_PERIOD = 2000;
    localparam int unsigned CONVST_WIDTH  = 8;
    localparam int unsigned BUSY_TIMEOUT  = 1024;
    localparam int unsigned EN_HOLD       = 8;
    localparam int unsigned NBITS         = 64;
    localparam int unsigned CS_LOW_CYC    = SCLK_DIV + NBITS * 2 * SCLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        adc_busy;
    logic        adc_sdo;
    logic        adc_convst;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [15:0] d0, d1, d2, d3;
    logic        e0, e1, e2, e3;
    logic        overrun;
    logic        busy_timeout;

    ads_spi_capture #(
        .SCLK_DIV     (SCLK_DIV),
        .SAMPLE_PERIOD(SAMPLE_PERIOD),
        .CONVST_WIDTH (CONVST_WIDTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .EN_HOLD      (EN_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .adc_busy    (adc_busy),
        .adc_sdo     (adc_sdo),
        .adc_convst  (adc_convst),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .Data0_out   (d0),
        .Data1_out   (d1),
        .Data2_out   (d2),
        .Data3_out   (d3),
        .Data0_out_en(e0),
        .Data1_out_en(e1),
        .Data2_out_en(e2),
        .Data3_out_en(e3),
        .overrun     (overrun),
        .busy_timeout(busy_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] frame;
        int unsigned dly;
        int unsigned len;
        bit          stuck;
    } plan_t;

    plan_t       plan_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] cur_frame = '0;
    logic [63:0] last_exp  = '0;
    logic [63:0] cur_exp   = '0;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ADC model: BUSY response to each CONVST, frame chosen from the plan queue.
    initial begin
        plan_t p;
        adc_busy = 1'b0;
        forever begin
            @(posedge adc_convst);
            if (plan_q.size() > 0) begin
                p = plan_q.pop_front();
            end else begin
                p.frame = '0; p.dly = 2; p.len = 20; p.stuck = 1'b0;
            end
            cur_frame = p.frame;
            if (!p.stuck) begin
                repeat (p.dly) @(negedge clk);
                adc_busy = 1'b1;
                repeat (p.len) @(negedge clk);
                adc_busy = 1'b0;
            end
        end
    end

    // ADC serial output: next bit, MSB first, on each SCLK falling edge.
    int unsigned bit_idx = 0;
    initial adc_sdo = 1'b0;
    always @(negedge adc_cs_n) bit_idx = 0;
    always @(negedge adc_sclk) begin
        if (!adc_cs_n) begin
            adc_sdo = (bit_idx < NBITS) ? cur_frame[63 - bit_idx] : 1'b0;
            bit_idx++;
        end
    end

    // Monitors: SPI framing, CONVST width, and the frame scoreboard.
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_en = 1'b0, prev_conv = 1'b0;
    int unsigned cs_low = 0, sclk_rises = 0, en_len = 0, conv_len = 0;
    bit          conv_in_read = 1'b0;
    int unsigned conv_rise_cyc = 0, conv_fall_cyc = 0, conv_count = 0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_cs = 1'b1; prev_sclk = 1'b1; prev_en = 1'b0; prev_conv = 1'b0;
            cs_low = 0; sclk_rises = 0; en_len = 0; conv_len = 0; conv_in_read = 1'b0;
        end else begin
            if (!adc_cs_n) begin
                cs_low++;
                if (adc_sclk && !prev_sclk) sclk_rises++;
                if (adc_convst) conv_in_read = 1'b1;
            end else if (!prev_cs) begin
                check("cs_low_len", 64'(cs_low), 64'(CS_LOW_CYC));
                check("sclk_rises", 64'(sclk_rises), 64'(NBITS));
                check("convst_in_read", 64'(conv_in_read), 64'(0));
                cs_low = 0; sclk_rises = 0; conv_in_read = 1'b0;
            end

            if (adc_convst) begin
                if (!prev_conv) begin
                    conv_rise_cyc = cyc;
                    conv_count++;
                end
                conv_len++;
            end else if (prev_conv) begin
                check("convst_width", 64'(conv_len), 64'(CONVST_WIDTH));
                conv_len = 0;
                conv_fall_cyc = cyc;
            end

            if (e0) begin
                if (!prev_en) begin
                    check("en_all", 64'({e0, e1, e2, e3}), 64'(4'hF));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_en: data 0x%0h with no frame outstanding",
                                 {d0, d1, d2, d3});
                        cur_exp = {d0, d1, d2, d3};
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("frame_data", {d0, d1, d2, d3}, cur_exp);
                    end
                end
                en_len++;
            end else if (prev_en) begin
                check("en_len", 64'(en_len), 64'(EN_HOLD));
                check("data_stable", {d0, d1, d2, d3}, cur_exp);
                en_len = 0;
            end

            prev_cs = adc_cs_n; prev_sclk = adc_sclk; prev_en = e0; prev_conv = adc_convst;
        end
    end

    task automatic push_frame(input logic [63:0] f, input int unsigned dly, input int unsigned len);
        plan_t p;
        p.frame = f; p.dly = dly; p.len = len; p.stuck = 1'b0;
        plan_q.push_back(p);
        exp_q.push_back(f);
        last_exp = f;
    endtask

    task automatic push_rand();
        push_frame({$urandom, $urandom}, $urandom_range(2, 20), $urandom_range(10, 60));
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || e0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: frame not delivered within %0d cycles, %0d outstanding",
                     name, budget, exp_q.size());
        end
    endtask

    task automatic wait_cs_low(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (adc_cs_n && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: cs_n never fell within %0d cycles", name, budget);
        end
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t1;
        int unsigned n;
        int unsigned tmo_cyc;
        plan_t       sp;

        rst = 1'b0;
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({adc_convst, adc_cs_n, adc_sclk}), 64'(3'b011));
        check("rst_data", {d0, d1, d2, d3}, 64'(0));
        check("rst_flags", 64'({e0, e1, e2, e3, overrun, busy_timeout}), 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, then the CONVST-to-CONVST period.
        push_frame(64'h1234_ABCD_8000_7FFF, 3, 40);
        run = 1'b1;
        wait_done("basic", 3000);
        t1 = conv_rise_cyc;
        push_rand();
        wait_done("period", 3000);
        check("sample_period", 64'(conv_rise_cyc - t1), 64'(SAMPLE_PERIOD));

        // Bit order / channel placement, then a few random frames.
        push_frame(64'h0001_0000_0000_0000, 5, 30);
        wait_done("bit_order", 3000);
        for (int i = 0; i < 3; i++) begin
            push_rand();
            wait_done("random", 3000);
        end

        // Long BUSY makes the frame outlast the sample period.
        check("overrun_pre", 64'(overrun), 64'(0));
        push_frame({$urandom, $urandom}, 900, 900);
        wait_done("long_frame", 5000);
        check("overrun_set", 64'(overrun), 64'(1));
        push_rand();
        wait_done("after_overrun", 3000);

        // BUSY never rises: timeout, no enable, outputs held.
        check("timeout_pre", 64'(busy_timeout), 64'(0));
        sp.frame = '1; sp.dly = 0; sp.len = 0; sp.stuck = 1'b1;
        plan_q.push_back(sp);
        n = 0;
        while (!busy_timeout && n < 5000) begin
            @(negedge clk);
            n++;
        end
        tmo_cyc = cyc;
        check("timeout_set", 64'(busy_timeout), 64'(1));
        check("timeout_delay", 64'(tmo_cyc - conv_fall_cyc), 64'(BUSY_TIMEOUT));
        check("timeout_hold_data", {d0, d1, d2, d3}, last_exp);
        push_rand();
        wait_done("after_timeout", 3000);

        // run dropped mid-READ: frame completes, no new starts until run returns.
        push_rand();
        wait_cs_low("run_toggle", 3000);
        repeat (50) @(negedge clk);
        run = 1'b0;
        wait_done("run_drop", 1500);
        n = conv_count;
        repeat (2500) @(negedge clk);
        check("no_convst_run0", 64'(conv_count), 64'(n));
        push_rand();
        run = 1'b1;
        @(negedge clk);
        check("convst_on_run", 64'(adc_convst), 64'(1));
        wait_done("run_restart", 3000);

        // Asynchronous reset in the middle of READ.
        push_rand();
        wait_cs_low("reset_mid", 3000);
        repeat (100) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_ctrl", 64'({adc_convst, adc_cs_n, adc_sclk}), 64'(3'b011));
        check("arst_data", {d0, d1, d2, d3}, 64'(0));
        check("arst_flags", 64'({e0, e1, e2, e3, overrun, busy_timeout}), 64'(0));
        exp_q.delete();
        plan_q.delete();
        last_exp = '0;
        repeat (3) @(negedge clk);
        push_rand();
        rst = 1'b1;
        wait_done("post_reset", 3000);
        check("post_reset_flags", 64'({overrun, busy_timeout}), 64'(0));

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
